// File: rtl/psum_accum_requant_pkg.sv
// Shared sizing and saturation helpers for requantization points
// (partial-sum accumulator, pooling, and similar stages).
package psum_accum_requant_pkg;

  // Accumulator width for summing num_accum words of 2*data_width bits without overflow.
  function automatic int acc_width(input int data_width, input int num_accum);
    return (num_accum > 1) ? 2 * data_width + $clog2(num_accum) : 2 * data_width;
  endfunction

  // Largest signed value representable in w bits.
  function automatic longint sat_max(input int w);
    return (longint'(1) <<< (w - 1)) - longint'(1);
  endfunction

  // Smallest signed value representable in w bits.
  function automatic longint sat_min(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

  // Saturation bounds for the common 8/16-bit feature-map words.
  localparam logic signed [7:0]  SAT_MAX_8  = 8'sh7F;
  localparam logic signed [7:0]  SAT_MIN_8  = 8'sh80;
  localparam logic signed [15:0] SAT_MAX_16 = 16'sh7FFF;
  localparam logic signed [15:0] SAT_MIN_16 = 16'sh8000;

endpackage

// File: rtl/psum_accum_requant_requant_sat.sv
// Combinational requantizer: round-half-up, arithmetic right shift by FRAC_BITS,
// saturate to OUT_W signed bits, then optional ReLU.
module requant_sat
  import psum_accum_requant_pkg::*;
#(
  parameter int IN_W      = 34,
  parameter int OUT_W     = 16,
  parameter int FRAC_BITS = 8,
  parameter int USE_RELU  = 1
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout
);

  // One guard bit so adding the rounding constant can never wrap.
  localparam int RW = IN_W + 1;
  localparam logic signed [RW-1:0] HALF = RW'(1) << (FRAC_BITS - 1);
  localparam logic signed [RW-1:0] MAXV = RW'(sat_max(OUT_W));
  localparam logic signed [RW-1:0] MINV = RW'(sat_min(OUT_W));

  logic signed [RW-1:0]    rnd;
  logic signed [RW-1:0]    shf;
  logic signed [OUT_W-1:0] sat;

  assign rnd = RW'(din) + HALF;
  assign shf = rnd >>> FRAC_BITS;

  // Clamp to the output range, then clamp negatives to zero when ReLU is enabled.
  always_comb begin
    sat = shf[OUT_W-1:0];
    if (shf > MAXV) begin
      sat = MAXV[OUT_W-1:0];
    end else if (shf < MINV) begin
      sat = MINV[OUT_W-1:0];
    end
    dout = sat;
    if ((USE_RELU != 0) && sat[OUT_W-1]) begin
      dout = '0;
    end
  end

endmodule

// File: rtl/psum_accum_requant.sv
// Sums NUM_ACCUM consecutive macc partial sums into a wide accumulator and
// requantizes each completed group to a DATA_WIDTH fixed-point word.
module psum_accum_requant
  import psum_accum_requant_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int NUM_ACCUM  = 4,
  parameter int USE_RELU   = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  output logic [DATA_WIDTH-1:0]   o_data,
  output logic                    o_valid,
  input  logic [DATA_WIDTH*2-1:0] i_data,
  input  logic                    i_valid,
  input  logic                    i_clear
);

  localparam int ACC_W = acc_width(DATA_WIDTH, NUM_ACCUM);
  localparam int CNT_W = (NUM_ACCUM > 1) ? $clog2(NUM_ACCUM) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_ACCUM - 1);

  logic signed [ACC_W-1:0]      ext;
  logic signed [ACC_W-1:0]      acc;
  logic [CNT_W-1:0]             cnt;
  logic                         sum_valid;
  logic signed [DATA_WIDTH-1:0] req_data;

  assign ext = ACC_W'($signed(i_data));

  // Stage A: load on the first beat of a group, add on later beats, flag the last beat.
  // The load path (rather than clearing after output) keeps back-to-back groups bubble-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      cnt       <= '0;
      sum_valid <= 1'b0;
    end else if (i_clear) begin
      sum_valid <= 1'b0;
      cnt       <= '0;
      if (i_valid) begin
        acc <= ext;
        if (NUM_ACCUM == 1) begin
          sum_valid <= 1'b1;
        end else begin
          cnt <= CNT_W'(1);
        end
      end
    end else if (i_valid) begin
      acc <= (cnt == '0) ? ext : acc + ext;
      if (cnt == LAST_CNT) begin
        cnt       <= '0;
        sum_valid <= 1'b1;
      end else begin
        cnt       <= cnt + CNT_W'(1);
        sum_valid <= 1'b0;
      end
    end else begin
      sum_valid <= 1'b0;
    end
  end

  requant_sat #(
    .IN_W     (ACC_W),
    .OUT_W    (DATA_WIDTH),
    .FRAC_BITS(FRAC_BITS),
    .USE_RELU (USE_RELU)
  ) u_requant_sat (
    .din (acc),
    .dout(req_data)
  );

  // Stage B: register the requantized word when a group total is ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_data  <= '0;
      o_valid <= 1'b0;
    end else begin
      o_valid <= sum_valid;
      if (sum_valid) begin
        o_data <= req_data;
      end
    end
  end

endmodule

// File: tb/tb_psum_accum_requant.sv
// Directed bench for psum_accum_requant: one ReLU and one linear instance share stimulus.
module tb_psum_accum_requant;

  logic        clk;
  logic        rst_n;
  logic [31:0] i_data;
  logic        i_valid;
  logic        i_clear;
  logic [15:0] o_data_r;
  logic        o_valid_r;
  logic [15:0] o_data_l;
  logic        o_valid_l;

  psum_accum_requant #(
    .DATA_WIDTH(16), .FRAC_BITS(8), .NUM_ACCUM(4), .USE_RELU(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .o_data(o_data_r), .o_valid(o_valid_r),
    .i_data(i_data), .i_valid(i_valid), .i_clear(i_clear)
  );

  psum_accum_requant #(
    .DATA_WIDTH(16), .FRAC_BITS(8), .NUM_ACCUM(4), .USE_RELU(0)
  ) dut_lin (
    .clk(clk), .rst_n(rst_n), .o_data(o_data_l), .o_valid(o_valid_l),
    .i_data(i_data), .i_valid(i_valid), .i_clear(i_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    int unsigned cyc;
  } exp_t;

  exp_t        q_r[$];
  exp_t        q_l[$];
  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_pass = 0;
  bit          ev_r;
  bit          ev_l;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Queue one expected output per instance, due two cycles after the beat driven next.
  task automatic expect_out(input logic [15:0] relu_v, input logic [15:0] lin_v);
    exp_t e;
    e.cyc = cyc + 2;
    e.d = relu_v;
    q_r.push_back(e);
    e.d = lin_v;
    q_l.push_back(e);
  endtask

  task automatic drive(input logic [31:0] d, input logic v, input logic c);
    i_data  = d;
    i_valid = v;
    i_clear = c;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) drive(32'h0, 1'b0, 1'b0);
  endtask

  task automatic beat(input logic [31:0] d, input bit is_last,
                      input logic [15:0] er, input logic [15:0] el);
    if (is_last) expect_out(er, el);
    drive(d, 1'b1, 1'b0);
  endtask

  task automatic gap_beat(input logic [31:0] d, input bit is_last,
                          input logic [15:0] er, input logic [15:0] el);
    idle($urandom_range(0, 2));
    beat(d, is_last, er, el);
  endtask

  // Output monitor: o_valid must match the expected schedule every cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      ev_r = (q_r.size() != 0) && (q_r[0].cyc == cyc);
      ev_l = (q_l.size() != 0) && (q_l[0].cyc == cyc);
      check("valid_relu", 32'(o_valid_r), 32'(ev_r));
      check("valid_lin", 32'(o_valid_l), 32'(ev_l));
      if (ev_r) begin
        check("data_relu", 32'(o_data_r), 32'(q_r[0].d));
        void'(q_r.pop_front());
      end
      if (ev_l) begin
        check("data_lin", 32'(o_data_l), 32'(q_l[0].d));
        void'(q_l.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n   = 1'b0;
    i_data  = '0;
    i_valid = 1'b0;
    i_clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid_relu", 32'(o_valid_r), 32'h0);
    check("rst_data_relu", 32'(o_data_r), 32'h0);
    check("rst_valid_lin", 32'(o_valid_l), 32'h0);
    check("rst_data_lin", 32'(o_data_l), 32'h0);
    rst_n = 1'b1;
    idle(2);

    // Basic: 4 x 1.0 back-to-back -> 4.0
    beat(32'h0001_0000, 0, 0, 0);
    beat(32'h0001_0000, 0, 0, 0);
    beat(32'h0001_0000, 0, 0, 0);
    beat(32'h0001_0000, 1, 16'h0400, 16'h0400);
    idle(3);

    // Rounding: 0x80 rounds up, 0x7F rounds down, -0x81 -> -1 (ReLU -> 0)
    beat(32'h0000_0080, 0, 0, 0);
    beat(32'h0, 0, 0, 0);
    beat(32'h0, 0, 0, 0);
    beat(32'h0, 1, 16'h0001, 16'h0001);
    beat(32'h0000_007F, 0, 0, 0);
    beat(32'h0, 0, 0, 0);
    beat(32'h0, 0, 0, 0);
    beat(32'h0, 1, 16'h0000, 16'h0000);
    beat(32'hFFFF_FF7F, 0, 0, 0);
    beat(32'h0, 0, 0, 0);
    beat(32'h0, 0, 0, 0);
    beat(32'h0, 1, 16'h0000, 16'hFFFF);
    idle(3);

    // Saturation: large positive clamps high; -2^31 clamps low (ReLU -> 0)
    beat(32'h7FFF_0000, 0, 0, 0);
    beat(32'h7FFF_0000, 0, 0, 0);
    beat(32'h7FFF_0000, 0, 0, 0);
    beat(32'h7FFF_0000, 1, 16'h7FFF, 16'h7FFF);
    beat(32'h8000_0000, 0, 0, 0);
    beat(32'h0, 0, 0, 0);
    beat(32'h0, 0, 0, 0);
    beat(32'h0, 1, 16'h0000, 16'h8000);
    idle(3);

    // Gapped groups followed immediately by gap-free groups
    gap_beat(32'h0001_0000, 0, 0, 0);
    gap_beat(32'h0002_0000, 0, 0, 0);
    gap_beat(32'h0003_0000, 0, 0, 0);
    gap_beat(32'h0004_0000, 1, 16'h0A00, 16'h0A00);
    gap_beat(32'h0000_8000, 0, 0, 0);
    gap_beat(32'h0000_8000, 0, 0, 0);
    gap_beat(32'h0000_8000, 0, 0, 0);
    gap_beat(32'h0000_8000, 1, 16'h0200, 16'h0200);
    beat(32'hFFFF_0000, 0, 0, 0);
    beat(32'hFFFF_0000, 0, 0, 0);
    beat(32'h0003_0000, 0, 0, 0);
    beat(32'h0000_0100, 1, 16'h0101, 16'h0101);
    beat(32'hFFFF_0000, 0, 0, 0);
    beat(32'hFFFF_0000, 0, 0, 0);
    beat(32'hFFFF_0000, 0, 0, 0);
    beat(32'hFFFF_0000, 1, 16'h0000, 16'hFC00);
    idle(3);

    // Clear with a valid beat starts a new group; the first two beats are dropped
    beat(32'h0005_0000, 0, 0, 0);
    beat(32'h0005_0000, 0, 0, 0);
    drive(32'h0001_0000, 1'b1, 1'b1);
    beat(32'h0001_0000, 0, 0, 0);
    beat(32'h0001_0000, 0, 0, 0);
    beat(32'h0001_0000, 1, 16'h0400, 16'h0400);
    idle(3);

    // Asynchronous reset mid-group clears outputs at once and drops the partial sum
    beat(32'h0003_0000, 0, 0, 0);
    beat(32'h0003_0000, 0, 0, 0);
    beat(32'h0003_0000, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    check("async_valid_relu", 32'(o_valid_r), 32'h0);
    check("async_data_relu", 32'(o_data_r), 32'h0);
    check("async_data_lin", 32'(o_data_l), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    beat(32'h0002_0000, 0, 0, 0);
    beat(32'h0002_0000, 0, 0, 0);
    beat(32'h0002_0000, 0, 0, 0);
    beat(32'h0002_0000, 1, 16'h0800, 16'h0800);
    idle(5);

    check("pending_relu", 32'(q_r.size()), 32'h0);
    check("pending_lin", 32'(q_l.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
